time_counter: RTL and testbench

Free-running time-of-day counter that consumes the preset produced by the time-entry splitter. While `PE_counter` is high it loads binary `pre_hour/pre_min/pre_sec`; otherwise it advances once per second from an internal prescaler of the system clock. It presents binary hour/minute/second to the display formatter and alarm comparator, and emits rollover strobes.

---
 rtl/time_counter.sv | 171 +++++++++++++++++
 tb/tb_time_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// time_counter: free-running binary time-of-day counter (hh:mm:ss).
//
// Loads a binary preset while PE_counter is high. Otherwise it advances once
// per second from an internal prescaler of clk. It emits one-cycle strobes on
// each advance, on each hour carry and on the midnight wrap, and one on every
// cycle that a preset is rejected.
//
// Optional feature: define TIME_COUNTER_CHIME_EN to build the hourly chime.
// The chime rises with hour_carry and holds for CHIME_SECS ticks. When the
// macro is undefined, chime is tied low and no chime counter is built.
module time_counter #(
   parameter int unsigned TICK_DIV   = 100_000_000,
   parameter int unsigned CHIME_SECS = 5
) (
   input  logic       clk,
   input  logic       _CR,
   input  logic       PE_counter,
   input  logic [7:0] pre_hour,
   input  logic [7:0] pre_min,
   input  logic [7:0] pre_sec,
   output logic [7:0] hour,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic       tick,
   output logic       hour_carry,
   output logic       day_wrap,
   output logic       load_err,
   output logic       chime
);

   // The prescaler is wide enough to hold TICK_DIV-1.
   localparam int unsigned   PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

   // Reject configurations the counter cannot represent.
   if (TICK_DIV < 2 || CHIME_SECS < 1) begin : g_param_chk
      $error("time_counter: TICK_DIV must be >= 2 and CHIME_SECS >= 1");
   end

   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    hour_q, hour_d;
   logic [7:0]    min_q, min_d;
   logic [7:0]    sec_q, sec_d;
   logic          tick_q, tick_d;
   logic          hour_carry_q, hour_carry_d;
   logic          day_wrap_q, day_wrap_d;
   logic          load_err_q, load_err_d;

   logic preset_ok;   // all three preset fields are within range
   logic adv;         // seconds advance on this edge
   logic carry_adv;   // this advance wraps the minute (hour carry)

   assign preset_ok = (pre_hour <= 8'd23) && (pre_min <= 8'd59) && (pre_sec <= 8'd59);

   // A load always wins over a terminal count, so that count is dropped.
   assign adv       = !PE_counter && (presc_q == TERM);
   assign carry_adv = adv && (sec_q == 8'd59) && (min_q == 8'd59);

   // Next-state logic: load, advance with cascaded wrap, or prescale.
   always_comb begin
      presc_d      = presc_q;
      hour_d       = hour_q;
      min_d        = min_q;
      sec_d        = sec_q;
      tick_d       = 1'b0;
      hour_carry_d = 1'b0;
      day_wrap_d   = 1'b0;
      load_err_d   = 1'b0;

      if (PE_counter) begin
         // Every load cycle restarts the second, whether or not the preset is accepted.
         presc_d = '0;
         if (preset_ok) begin
            hour_d = pre_hour;
            min_d  = pre_min;
            sec_d  = pre_sec;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (adv) begin
         presc_d = '0;
         tick_d  = 1'b1;
         if (sec_q == 8'd59) begin
            sec_d = 8'd0;
            if (min_q == 8'd59) begin
               min_d        = 8'd0;
               hour_carry_d = 1'b1;
               if (hour_q == 8'd23) begin
                  hour_d     = 8'd0;
                  day_wrap_d = 1'b1;
               end else begin
                  hour_d = hour_q + 8'd1;
               end
            end else begin
               min_d = min_q + 8'd1;
            end
         end else begin
            sec_d = sec_q + 8'd1;
         end
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   // State and strobe registers; the synchronous reset overrides load and count.
   always_ff @(posedge clk) begin
      if (!_CR) begin
         presc_q      <= '0;
         hour_q       <= 8'd0;
         min_q        <= 8'd0;
         sec_q        <= 8'd0;
         tick_q       <= 1'b0;
         hour_carry_q <= 1'b0;
         day_wrap_q   <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         hour_q       <= hour_d;
         min_q        <= min_d;
         sec_q        <= sec_d;
         tick_q       <= tick_d;
         hour_carry_q <= hour_carry_d;
         day_wrap_q   <= day_wrap_d;
         load_err_q   <= load_err_d;
      end
   end

   assign hour       = hour_q;
   assign min        = min_q;
   assign sec        = sec_q;
   assign tick       = tick_q;
   assign hour_carry = hour_carry_q;
   assign day_wrap   = day_wrap_q;
   assign load_err   = load_err_q;

`ifdef TIME_COUNTER_CHIME_EN
   localparam int unsigned CW = $clog2(CHIME_SECS + 1);

   logic [CW-1:0] chime_cnt_q, chime_cnt_d;
   logic          chime_q;

   // Chime countdown: an hour carry (re)loads it, and each later tick decrements it.
   always_comb begin
      chime_cnt_d = chime_cnt_q;
      if (PE_counter) begin
         chime_cnt_d = '0;
      end else if (carry_adv) begin
         chime_cnt_d = CW'(CHIME_SECS);
      end else if (adv && (chime_cnt_q != '0)) begin
         chime_cnt_d = chime_cnt_q - CW'(1);
      end
   end

   // The chime level is registered from the next count, so it rises with
   // hour_carry and falls with the last tick.
   always_ff @(posedge clk) begin
      if (!_CR) begin
         chime_cnt_q <= '0;
         chime_q     <= 1'b0;
      end else begin
         chime_cnt_q <= chime_cnt_d;
         chime_q     <= (chime_cnt_d != '0);
      end
   end

   assign chime = chime_q;
`else
   assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter. A time-of-day model, kept as seconds since midnight,
// is checked against the DUT on every cycle. Directed literal checks pin the
// scenarios, and a randomized phase follows them.
module tb_time_counter;

   localparam int TD = 4;
   localparam int CS = 5;
`ifdef TIME_COUNTER_CHIME_EN
   localparam int CH = 1;
`else
   localparam int CH = 0;
`endif

   logic       clk = 1'b0;
   logic       cr_n, pe;
   logic [7:0] ph, pm, ps;
   logic [7:0] hour_o, min_o, sec_o;
   logic       tick_o, hc_o, dw_o, err_o, chime_o;

   int n_chk  = 0;
   int n_pass = 0;

   time_counter #(.TICK_DIV(TD), .CHIME_SECS(CS)) dut (
      .clk(clk), ._CR(cr_n), .PE_counter(pe),
      .pre_hour(ph), .pre_min(pm), .pre_sec(ps),
      .hour(hour_o), .min(min_o), .sec(sec_o),
      .tick(tick_o), .hour_carry(hc_o), .day_wrap(dw_o),
      .load_err(err_o), .chime(chime_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Model state: time as seconds of the day plus cycles into the current second.
   int tod = 0, cyc = 0, chime_left = 0;
   bit m_tick, m_hc, m_dw, m_err, mvalid = 0;

   initial forever begin
      @(posedge clk);
      m_tick = 0; m_hc = 0; m_dw = 0; m_err = 0;
      if (!cr_n) begin
         tod = 0; cyc = 0; chime_left = 0; mvalid = 1;
      end else if (mvalid) begin
         if (pe) begin
            cyc = 0; chime_left = 0;
            if (ph <= 23 && pm <= 59 && ps <= 59) tod = ph * 3600 + pm * 60 + ps;
            else m_err = 1;
         end else begin
            cyc++;
            if (cyc == TD) begin
               cyc = 0;
               tod = (tod + 1) % 86400;
               m_tick = 1;
               m_hc = (tod % 3600 == 0);
               m_dw = (tod == 0);
               if (m_hc) chime_left = CS;
               else if (chime_left > 0) chime_left--;
            end
         end
      end
      @(negedge clk);
      if (mvalid) begin
         chk("m_hour", hour_o, tod / 3600);
         chk("m_min", min_o, (tod / 60) % 60);
         chk("m_sec", sec_o, tod % 60);
         chk("m_tick", tick_o, m_tick);
         chk("m_hour_carry", hc_o, m_hc);
         chk("m_day_wrap", dw_o, m_dw);
         chk("m_load_err", err_o, m_err);
         chk("m_chime", chime_o, (CH != 0 && chime_left > 0) ? 1 : 0);
      end
   end

   task automatic all_zero(input string tag);
      chk({tag, "_hour"}, hour_o, 0);
      chk({tag, "_min"}, min_o, 0);
      chk({tag, "_sec"}, sec_o, 0);
      chk({tag, "_tick"}, tick_o, 0);
      chk({tag, "_hc"}, hc_o, 0);
      chk({tag, "_dw"}, dw_o, 0);
      chk({tag, "_err"}, err_o, 0);
      chk({tag, "_chime"}, chime_o, 0);
   endtask

   task automatic preset(input int h, input int m, input int s, input int n);
      pe = 1; ph = 8'(h); pm = 8'(m); ps = 8'(s);
      repeat (n) @(negedge clk);
      pe = 0;
   endtask

   int hold;

   initial begin
      cr_n = 0; pe = 0; ph = 0; pm = 0; ps = 0;
      repeat (2) @(negedge clk);
      all_zero("rst");
      cr_n = 1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k % 4 == 0) begin
            chk("run_tick", tick_o, 1);
            chk("run_sec", sec_o, k / 4);
         end else chk("run_notick", tick_o, 0);
      end

      // Midnight wrap after a long preset hold.
      preset(23, 59, 58, 10);
      chk("pl_sec", sec_o, 58);
      repeat (4) @(negedge clk);
      chk("pl_sec59", sec_o, 59);
      chk("pl_dw_early", dw_o, 0);
      repeat (4) @(negedge clk);
      chk("wrap_hour", hour_o, 0);
      chk("wrap_sec", sec_o, 0);
      chk("wrap_hc", hc_o, 1);
      chk("wrap_dw", dw_o, 1);
      @(negedge clk);
      chk("wrap_hc_1cyc", hc_o, 0);
      chk("wrap_dw_1cyc", dw_o, 0);

      // Rejected preset held for three cycles.
      pe = 1; ph = 12; pm = 60; ps = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bad_err", err_o, 1);
         chk("bad_notick", tick_o, 0);
         chk("bad_hour", hour_o, 0);
      end
      pe = 0;
      @(negedge clk);
      chk("bad_err_off", err_o, 0);

      // Hour carry with no day wrap, followed by the chime window.
      preset(10, 59, 59, 2);
      repeat (4) @(negedge clk);
      chk("hc_hour", hour_o, 11);
      chk("hc_min", min_o, 0);
      chk("hc_sec", sec_o, 0);
      chk("hc_hc", hc_o, 1);
      chk("hc_dw", dw_o, 0);
      chk("hc_chime", chime_o, CH);
      repeat (4 * TD) @(negedge clk);
      chk("chime_4th", chime_o, CH);
      repeat (TD) @(negedge clk);
      chk("chime_5th", chime_o, 0);

      // A load that coincides with the terminal count drops that count.
      preset(7, 7, 7, 1);
      repeat (TD - 1) @(negedge clk);
      pe = 1; ph = 1; pm = 2; ps = 3;
      @(negedge clk);
      pe = 0;
      chk("coll_tick", tick_o, 0);
      chk("coll_hour", hour_o, 1);
      chk("coll_min", min_o, 2);
      chk("coll_sec", sec_o, 3);

      // Reset in the middle of a chime, then a full second from zero.
      preset(4, 59, 59, 1);
      repeat (TD) @(negedge clk);
      chk("c5_hour", hour_o, 5);
      chk("c5_chime", chime_o, CH);
      repeat (2 * TD) @(negedge clk);
      chk("c5_sec", sec_o, 2);
      repeat (2) @(negedge clk);
      cr_n = 0;
      @(negedge clk);
      all_zero("mid_rst");
      cr_n = 1;
      repeat (TD - 1) @(negedge clk);
      chk("rr_notick", tick_o, 0);
      @(negedge clk);
      chk("rr_tick", tick_o, 1);
      chk("rr_sec", sec_o, 1);

      // Randomized phase: the per-cycle model compare does the checking.
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         cr_n = ($urandom_range(0, 199) != 0);
         if (hold > 0) hold--;
         else if ($urandom_range(0, 39) == 0) begin
            hold = $urandom_range(1, 12);
            pe = 1;
            ph = 8'($urandom_range(0, 23));
            pm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 59)) : 8'd59;
            ps = 8'($urandom_range(55, 59));
            if ($urandom_range(0, 7) == 0) begin
               case ($urandom_range(0, 2))
                  0: ph = 8'($urandom_range(24, 255));
                  1: pm = 8'($urandom_range(60, 255));
                  default: ps = 8'($urandom_range(60, 255));
               endcase
            end
         end else pe = 0;
         @(negedge clk);
      end
      pe = 0; cr_n = 1;
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
